// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic for the 5-stage MIPS pipeline: ALU-control decode,
// a 32-bit ALU, a standalone adder, and the EX/MEM output register.
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] add_a,
  input  logic [31:0] add_b,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] add_sum
);

  localparam logic [3:0] CtrlAnd  = 4'b0000;
  localparam logic [3:0] CtrlOr   = 4'b0001;
  localparam logic [3:0] CtrlAdd  = 4'b0010;
  localparam logic [3:0] CtrlSub  = 4'b0110;
  localparam logic [3:0] CtrlSlt  = 4'b0111;
  localparam logic [3:0] CtrlNor  = 4'b1100;
  localparam logic [3:0] CtrlIllg = 4'b1111;

  logic [31:0] aluNext;
  logic [31:0] sumNext;
  logic [31:0] diff;
  logic        sltBit;

  always_comb begin
    alu_ctrl = CtrlIllg;
    case (alu_op)
      3'b000: alu_ctrl = CtrlAdd;
      3'b001: alu_ctrl = CtrlSub;
      3'b010: begin
        case (funct)
          6'b100000: alu_ctrl = CtrlAdd;
          6'b100010: alu_ctrl = CtrlSub;
          6'b100100: alu_ctrl = CtrlAnd;
          6'b100101: alu_ctrl = CtrlOr;
          6'b100111: alu_ctrl = CtrlNor;
          6'b101010: alu_ctrl = CtrlSlt;
          default:   alu_ctrl = CtrlIllg;
        endcase
      end
      3'b011:  alu_ctrl = CtrlAnd;
      3'b100:  alu_ctrl = CtrlOr;
      3'b101:  alu_ctrl = CtrlSlt;
      default: alu_ctrl = CtrlIllg;
    endcase
  end

  // Signed less-than from the subtractor: differing signs decide directly,
  // otherwise the sign of the (non-overflowing) difference decides.
  assign diff   = op_a - op_b;
  assign sltBit = (op_a[31] != op_b[31]) ? op_a[31] : diff[31];

  always_comb begin
    aluNext = 32'd0;
    case (alu_ctrl)
      CtrlAnd: aluNext = op_a & op_b;
      CtrlOr:  aluNext = op_a | op_b;
      CtrlAdd: aluNext = op_a + op_b;
      CtrlSub: aluNext = diff;
      CtrlSlt: aluNext = {31'd0, sltBit};
      CtrlNor: aluNext = ~(op_a | op_b);
      default: aluNext = 32'd0;
    endcase
  end

  assign sumNext = add_a + add_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_result <= 32'd0;
      zero       <= 1'b0;
      add_sum    <= 32'd0;
    end else if (en) begin
      alu_result <= aluNext;
      zero       <= (aluNext == 32'd0);
      add_sum    <= sumNext;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: a behavioural model checked every
// negative clock edge, plus directed vectors with hand-computed results.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  alu_op = 3'd0;
  logic [5:0]  funct = 6'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] add_a = 32'd0;
  logic [31:0] add_b = 32'd0;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] add_sum;

  int nAssert = 0;
  int nFail = 0;
  logic checkOn = 1'b0;

  alu_exec_unit dut (
    .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
    .op_a(op_a), .op_b(op_b), .add_a(add_a), .add_b(add_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero), .add_sum(add_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ctrlOf(input logic [2:0] op, input logic [5:0] f);
    logic [3:0] c;
    c = 4'hF;
    if (op == 3'd0) c = 4'h2;
    else if (op == 3'd1) c = 4'h6;
    else if (op == 3'd3) c = 4'h0;
    else if (op == 3'd4) c = 4'h1;
    else if (op == 3'd5) c = 4'h7;
    else if (op == 3'd2) begin
      if (f == 6'h20) c = 4'h2;
      else if (f == 6'h22) c = 4'h6;
      else if (f == 6'h24) c = 4'h0;
      else if (f == 6'h25) c = 4'h1;
      else if (f == 6'h27) c = 4'hC;
      else if (f == 6'h2A) c = 4'h7;
    end
    return c;
  endfunction

  function automatic logic [31:0] resultOf(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (c == 4'h0) return a & b;
    if (c == 4'h1) return a | b;
    if (c == 4'h2) return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
    if (c == 4'h6) return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
    if (c == 4'h7) return (sa < sb) ? 32'd1 : 32'd0;
    if (c == 4'hC) return ~(a | b);
    return 32'd0;
  endfunction

  logic [31:0] expRes = 32'd0;
  logic [31:0] expSum = 32'd0;
  logic        expZero = 1'b0;

  always @(posedge clk) begin
    if (reset && en) begin
      expRes  = resultOf(ctrlOf(alu_op, funct), op_a, op_b);
      expZero = (expRes == 32'd0);
      expSum  = add_a + add_b;
    end
  end

  always @(negedge reset) begin
    expRes  = 32'd0;
    expZero = 1'b0;
    expSum  = 32'd0;
  end

  always @(negedge clk) begin
    if (checkOn) begin
      check("model_ctrl", {28'd0, alu_ctrl}, {28'd0, ctrlOf(alu_op, funct)});
      check("model_result", alu_result, expRes);
      check("model_zero", {31'd0, zero}, {31'd0, expZero});
      check("model_sum", add_sum, expSum);
    end
  end

  task automatic apply(input logic [2:0] op, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] aa, input logic [31:0] ab);
    alu_op = op; funct = f; op_a = a; op_b = b; add_a = aa; add_b = ab;
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  sweepFunct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
  logic [3:0]  sweepCtrl  [6] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7};
  logic [31:0] sweepRes   [6] = '{32'h0000_00FF, 32'hFFFF_FF1F, 32'h0, 32'h0000_00FF,
                                  32'hFFFF_FF00, 32'h1};

  initial begin
    #1;
    check("reset_result", alu_result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd0);
    check("reset_sum", add_sum, 32'd0);
    checkOn = 1'b1;
    #11;
    reset = 1'b1;
    en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      alu_op = 3'b010; funct = sweepFunct[i]; op_a = 32'h0000_000F; op_b = 32'h0000_00F0;
      add_a = 32'(i); add_b = 32'd100;
      #1;
      check("rtype_ctrl", {28'd0, alu_ctrl}, {28'd0, sweepCtrl[i]});
      @(posedge clk);
      #1;
      check("rtype_result", alu_result, sweepRes[i]);
      check("rtype_zero", {31'd0, zero}, (sweepRes[i] == 32'd0) ? 32'd1 : 32'd0);
    end

    apply(3'b101, 6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    check("slt_neg_lt_pos", alu_result, 32'd1);
    apply(3'b101, 6'h00, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("slt_pos_lt_neg", alu_result, 32'd0);
    apply(3'b000, 6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    check("add_wrap_result", alu_result, 32'd0);
    check("add_wrap_zero", {31'd0, zero}, 32'd1);

    apply(3'b001, 6'h00, 32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0);
    check("beq_equal_zero", {31'd0, zero}, 32'd1);
    apply(3'b001, 6'h00, 32'h1234_5678, 32'h1234_5679, 32'h0, 32'h0);
    check("beq_ne_zero", {31'd0, zero}, 32'd0);
    check("beq_ne_result", alu_result, 32'hFFFF_FFFF);

    apply(3'b011, 6'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0040_0004, 32'h0000_0010);
    check("adder_pc", add_sum, 32'h0040_0014);
    check("andi_result", alu_result, 32'h00F0_1234);
    apply(3'b100, 6'h00, 32'hF000_0000, 32'h0000_000F, 32'hFFFF_FFFC, 32'h4);
    check("adder_wrap", add_sum, 32'd0);
    check("ori_result", alu_result, 32'hF000_000F);

    apply(3'b000, 6'h00, 32'd5, 32'd7, 32'd1, 32'd2);
    check("pre_stall_result", alu_result, 32'd12);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(3'b001, 6'h00, 32'(i * 3), 32'(i * 3), 32'(100 + i), 32'd9);
      check("stall_result", alu_result, 32'd12);
      check("stall_zero", {31'd0, zero}, 32'd0);
      check("stall_sum", add_sum, 32'd3);
    end
    en = 1'b1;

    alu_op = 3'b010; funct = 6'b000000; op_a = 32'h55; op_b = 32'hAA;
    #1;
    check("illegal_ctrl", {28'd0, alu_ctrl}, 32'hF);
    @(posedge clk);
    #1;
    check("illegal_result", alu_result, 32'd0);
    check("illegal_zero", {31'd0, zero}, 32'd1);
    apply(3'b110, 6'h20, 32'h1, 32'h2, 32'h0, 32'h0);
    check("op110_ctrl", {28'd0, alu_ctrl}, 32'hF);
    check("op110_zero", {31'd0, zero}, 32'd1);
    apply(3'b111, 6'h25, 32'h1, 32'h2, 32'h0, 32'h0);
    check("op111_result", alu_result, 32'd0);

    apply(3'b100, 6'h00, 32'h0000_00F0, 32'h0000_000F, 32'h10, 32'h20);
    check("pre_reset_result", alu_result, 32'h0000_00FF);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_result", alu_result, 32'd0);
    check("async_reset_sum", add_sum, 32'd0);
    check("async_reset_zero", {31'd0, zero}, 32'd0);
    @(posedge clk);
    #1;
    check("held_reset_result", alu_result, 32'd0);
    check("held_reset_sum", add_sum, 32'd0);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_result", alu_result, 32'h0000_00FF);
    check("post_reset_sum", add_sum, 32'h30);

    repeat (2) @(posedge clk);
    #1;
    checkOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic block for the 5-stage MIPS pipeline. It combines three functions:
- ALU-control decode from the 3-bit main-decoder ALUOp and the instruction funct field.
- 32-bit ALU.
- Free-standing 32-bit adder, used for PC+4 or branch-target calculation.

ALU result, zero flag and adder sum are registered once per clock, and the register feeds the EX/MEM boundary.

## Interface
- No parameters; all datapaths are fixed at 32 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset: 0 clears all registers immediately.
- en  input  1  register update enable; 0 holds all registered outputs (pipeline stall).
- alu_op  input  3  ALUOp from the main control decoder.
- funct  input  6  instruction bits [5:0].
- op_a  input  32  ALU operand A (already forwarded).
- op_b  input  32  ALU operand B (already muxed: register or sign-extended immediate).
- add_a  input  32  adder operand A.
- add_b  input  32  adder operand B.
- alu_ctrl  output  4  decoded ALU control; combinational, not registered.
- alu_result  output  32  registered ALU result.
- zero  output  1  registered flag; 1 when the ALU result was all zeros.
- add_sum  output  32  registered add_a + add_b.

## Operation
- **ALU-control decode** (combinational, alu_op priority):
  - 000 → ADD 0010 (lw/sw/addi).
  - 001 → SUB 0110 (beq/bne).
  - 010 → R-type; decode funct:
    - 100000 → ADD 0010.
    - 100010 → SUB 0110.
    - 100100 → AND 0000.
    - 100101 → OR 0001.
    - 100111 → NOR 1100.
    - 101010 → SLT 0111.
    - Any other funct → 1111.
  - 011 → AND 0000 (andi).
  - 100 → OR 0001 (ori).
  - 101 → SLT 0111 (slti).
  - 110 and 111 → 1111.
- **ALU functions** (operands A = op_a, B = op_b):
  - AND: A & B.
  - OR: A | B.
  - ADD: A + B mod 2^32.
  - SUB: A − B mod 2^32.
  - SLT: 1 if A < B as signed two's complement, else 0; zero-extended to 32 bits.
  - NOR: ~(A | B).
  - 1111 (illegal): result 0.
- **Overflow**: none detected, none flagged, no trap; ADD and SUB wrap silently.
- **zero flag**: computed on the unregistered ALU result, then registered alongside it.
  - An illegal op therefore registers zero=1.
- **Adder**: add_a + add_b mod 2^32, carry discarded; independent of alu_op and funct.

## Timing
- alu_ctrl is purely combinational from alu_op/funct, with zero latency.
- alu_result, zero and add_sum have one-cycle latency.
  - They capture on the rising clk edge where en=1 and reset=1.
  - They are valid from that edge until the next capturing edge.
- en=0 holds all three registered outputs at their previous values. alu_ctrl still tracks its inputs.
- reset=0 at any time, including mid-operation or coincident with a clock edge, forces:
  - alu_result = 0.
  - add_sum = 0.
  - zero = 0.
- While reset=0, clock edges are ignored. The first capture happens on the first rising edge after reset returns to 1 with en=1.
- When en=1 and reset deasserts on the same edge, no capture occurs on that edge.
- There are no handshakes and no state machine; the block behaves as a plain pipeline register stage.

## Test plan
- **Reset:**
  - Stimulus: drive reset=0 mid-run after nonzero results.
  - Response: alu_result=0, add_sum=0 and zero=0 immediately, with no clock edge needed.
- **R-type sweep:** alu_op=010, op_a=0x0000_000F, op_b=0x0000_00F0 → after one edge:
  - add: 0xFF.
  - sub: 0xFFFF_FF1F.
  - and: 0.
  - or: 0xFF.
  - nor: 0xFFFF_FF00.
  - slt: 1.
  - alu_ctrl for each: 0010, 0110, 0000, 0001, 1100, 0111.
- **Signed SLT and wrap:**
  - alu_op=101, op_a=0xFFFF_FFFF (−1), op_b=1 → 1. Swapping the operands → 0.
  - alu_op=000, op_a=0xFFFF_FFFF, op_b=1 → result 0, zero=1.
- **Branch compare:**
  - alu_op=001, op_a=op_b=0x1234_5678 → zero=1.
  - op_b=0x1234_5679 → zero=0, result 0xFFFF_FFFF.
- **Adder:**
  - add_a=0x0040_0004, add_b=0x0000_0010 → add_sum=0x0040_0014.
  - 0xFFFF_FFFC + 4 → 0.
- **Stall and illegal op:**
  - en=0 for 3 cycles with changing inputs → outputs frozen.
  - alu_op=010, funct=000000 → alu_ctrl=1111, then result 0 and zero=1.
